alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, shall set the operand width.
REQ-002 Parameter CMD_WIDTH, default 4, shall set the command width.
REQ-003 Parameter ALU_LAT, default 1, minimum 1, shall set the number of WAIT cycles for non-multiply commands.
REQ-004 Parameter MUL_LAT, default 2, minimum 1, shall set the number of WAIT cycles for MODE=1 CMD 9 or 10.
REQ-005 Port CLK, in, 1: the single clock; all flops shall be rising-edge.
REQ-006 Port RESET, in, 1: the reset, which shall be asynchronous and active-high.
REQ-007 Port req_valid, in, 2: per-requester request valid.
REQ-008 Port req_ready, out, 2: per-requester accept; at most one bit shall be high.
REQ-009 Port req_pkt, in, 2 x alu_req_t: per-requester {mode, cin, inp_valid[1:0], cmd, opa, opb}.
REQ-010 Port rsp_valid, out, 1: response valid.
REQ-011 Port rsp_ready, in, 1: response accept from the consumer.
REQ-012 Port rsp_pkt, out, alu_rsp_t: {id, res[DATA_WIDTH+1:0], err, cout, oflow, e, g, l}.
REQ-013 Port alu_ce, out, 1: drives the ALU CE input.
REQ-014 Port alu_req, out, alu_req_t: drives the ALU MODE, CIN, INP_VALID, CMD, OPA and OPB inputs.
REQ-015 Port alu_res, in, DATA_WIDTH+2: the ALU RES output.
REQ-016 Port alu_flags, in, 6: the ALU outputs as {ERR, COUT, OFLOW, E, G, L}.

Function
REQ-017 The block shall implement an FSM with states IDLE, ISSUE, WAIT and RESP, and shall allow only one transaction outstanding at a time.
REQ-018 In IDLE, req_ready shall be high only for the current grant winner, and only while that requester's req_valid is high; in all other states req_ready shall be 0.
REQ-019 Arbitration shall be two-way round-robin:
- if one requester is valid, it shall win;
- if both are valid, the requester named by the priority pointer shall win;
- on each accept, the pointer shall move to the other requester.
REQ-020 On accept, the block shall register the winning req_pkt into alu_req and register the winner's id; alu_req shall change only on an accept.
REQ-021 On accept of a valid command, the FSM shall go IDLE -> ISSUE.
REQ-022 A command shall be invalid when any of the following holds:
- MODE=1 and CMD>10;
- MODE=0 and CMD>13;
- inp_valid=2'b00.
REQ-023 On accept of an invalid command, the FSM shall go IDLE -> RESP, with alu_ce held at 0 throughout and rsp_pkt set to res=0, err=1, all other flags 0.
REQ-024 ISSUE shall last exactly 1 cycle with alu_ce=1, and shall load the latency counter with MUL_LAT or ALU_LAT according to REQ-003/REQ-004.
REQ-025 WAIT shall hold alu_ce=1 and alu_req stable, and shall last exactly the loaded count of cycles.
REQ-026 On the final WAIT edge, the block shall capture alu_res and alu_flags into rsp_pkt and go to RESP.
REQ-027 Response timing for a valid command accepted at edge 0: rsp_valid shall rise after edge LAT+2, where LAT is the loaded count.
REQ-028 In RESP:
- alu_ce shall be 0;
- rsp_valid shall be 1;
- rsp_pkt shall be held stable until rsp_ready is sampled high;
- on that handshake the FSM shall go to IDLE.
REQ-029 A new request shall not be accepted in the same cycle as a response handshake; the earliest next accept shall be in the following IDLE cycle.
REQ-030 A change on req_valid or req_pkt outside IDLE shall have no effect on the block.

Reset
REQ-031 While RESET is high, the block shall hold: state=IDLE, req_ready=0, rsp_valid=0, rsp_pkt=0, alu_ce=0, alu_req=0, pointer=requester 0, counter=0.
REQ-032 RESET asserted in any state shall immediately discard the in-flight transaction, and no response for it shall ever be issued.

Structure
REQ-033 Package alu_arb_pkg shall hold:
- alu_req_t and alu_rsp_t;
- the state enum;
- the constants MAX_CMD_MODE1=10, MAX_CMD_MODE0=13, MUL_CMD_A=9 and MUL_CMD_B=10.
REQ-034 The round-robin grant logic and its pointer shall live in the sub-module alu_rr_arb.

Verification
REQ-035 Scenario "single add": req0 sends MODE=1, CMD=0, OPA=8'h0F, OPB=8'h01, inp_valid=2'b11 -> alu_ce high for 2 cycles; rsp_valid after edge 3; rsp res=10'h010, id=0.
REQ-036 Scenario "contention": both requesters valid from reset release -> req0 served first, then req1; repeating both valid shall alternate 0,1,0,1.
REQ-037 Scenario "invalid command": req1 sends MODE=1, CMD=12 -> alu_ce stays 0; rsp_valid after edge 1 with err=1, res=0, id=1.
REQ-038 Scenario "multiply": MODE=1, CMD=9, OPA=3, OPB=4, MUL_LAT=2 -> rsp_valid after edge 4, res matches the ALU model.
REQ-039 Scenario "backpressure": rsp_ready held 0 for 5 cycles -> rsp_pkt stable, req_ready=0 throughout; accept possible 1 cycle after the handshake.
REQ-040 Scenario "reset mid-WAIT": RESET pulsed during WAIT -> all outputs 0 immediately; no rsp_valid for that request.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU front-end arbiter.
// The struct field widths are fixed here; the top-level DATA_WIDTH and
// CMD_WIDTH parameters must be left at values matching these widths.
package alu_arb_pkg;

  localparam int ARB_DATA_WIDTH = 8;
  localparam int ARB_CMD_WIDTH  = 4;

  localparam logic [ARB_CMD_WIDTH-1:0] MAX_CMD_MODE1 = 4'd10;
  localparam logic [ARB_CMD_WIDTH-1:0] MAX_CMD_MODE0 = 4'd13;
  localparam logic [ARB_CMD_WIDTH-1:0] MUL_CMD_A     = 4'd9;
  localparam logic [ARB_CMD_WIDTH-1:0] MUL_CMD_B     = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  typedef struct packed {
    logic                      mode;
    logic                      cin;
    logic [1:0]                inp_valid;
    logic [ARB_CMD_WIDTH-1:0]  cmd;
    logic [ARB_DATA_WIDTH-1:0] opa;
    logic [ARB_DATA_WIDTH-1:0] opb;
  } alu_req_t;

  typedef struct packed {
    logic                      id;
    logic [ARB_DATA_WIDTH+1:0] res;
    logic                      err;
    logic                      cout;
    logic                      oflow;
    logic                      e;
    logic                      g;
    logic                      l;
  } alu_rsp_t;

  // Multiplies are the arithmetic-mode commands that need the longer latency.
  function automatic logic is_mul_cmd(input alu_req_t r);
    return r.mode && ((r.cmd == MUL_CMD_A) || (r.cmd == MUL_CMD_B));
  endfunction

endpackage

// File: rtl/alu_rr_arb.sv
// Two-way round-robin grant logic. The pointer names the requester that
// wins a tie; after every accepted grant it moves to the other requester.
module alu_rr_arb
  import alu_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic ptr_q;
  logic ptr_d;

  // Pick the winner: a lone requester always wins, a tie goes to the pointer.
  always_comb begin
    grant    = 2'b00;
    grant_id = (&req_valid) ? ptr_q : req_valid[1];
    if (|req_valid) begin
      grant[grant_id] = 1'b1;
    end
    ptr_d = accept ? ~grant_id : ptr_q;
  end

  // Priority pointer register, starting at requester 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Front end that lets two requesters share one multi-cycle ALU.
// One transaction is in flight at a time: a request is accepted in IDLE,
// the ALU is enabled for one ISSUE cycle plus a latency-dependent number of
// WAIT cycles, and the captured result is offered in RESP until taken.
// Malformed commands bypass the ALU and go straight to an error response.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CMD_WIDTH  = 4,
  parameter int ALU_LAT    = 1,
  parameter int MUL_LAT    = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  alu_req_t [1:0]        req_pkt,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output alu_rsp_t              rsp_pkt,
  output logic                  alu_ce,
  output alu_req_t              alu_req,
  input  logic [DATA_WIDTH+1:0] alu_res,
  input  logic [5:0]            alu_flags
);

  localparam int CNT_MAX = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  arb_state_e           state_q;
  arb_state_e           state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  alu_req_t             alu_req_q;
  alu_req_t             alu_req_d;
  alu_rsp_t             rsp_q;
  alu_rsp_t             rsp_d;
  logic                 id_q;
  logic                 id_d;

  logic [1:0]           grant;
  logic                 win_id;
  logic                 accept;
  alu_req_t             win_pkt;
  logic [CMD_WIDTH-1:0] win_cmd;
  logic                 cmd_invalid;

  alu_rr_arb u_rr_arb (
    .clk       (CLK),
    .rst       (RESET),
    .req_valid (req_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_id  (win_id)
  );

  // Handshake and command decode for the current grant winner.
  always_comb begin
    req_ready   = ((state_q == IDLE) && !RESET) ? grant : 2'b00;
    accept      = |req_ready;
    win_pkt     = req_pkt[win_id];
    win_cmd     = win_pkt.cmd;
    cmd_invalid = (win_pkt.inp_valid == 2'b00) ||
                  (win_pkt.mode  && (win_cmd > MAX_CMD_MODE1)) ||
                  (!win_pkt.mode && (win_cmd > MAX_CMD_MODE0));
  end

  // Next-state logic for the transaction FSM and its data registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_req_d = alu_req_q;
    rsp_d     = rsp_q;
    id_d      = id_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          alu_req_d = win_pkt;
          id_d      = win_id;
          if (cmd_invalid) begin
            rsp_d     = '0;
            rsp_d.id  = win_id;
            rsp_d.err = 1'b1;
            state_d   = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = is_mul_cmd(alu_req_q) ? CNT_W'(MUL_LAT) : CNT_W'(ALU_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          rsp_d.id    = id_q;
          rsp_d.res   = alu_res;
          rsp_d.err   = alu_flags[5];
          rsp_d.cout  = alu_flags[4];
          rsp_d.oflow = alu_flags[3];
          rsp_d.e     = alu_flags[2];
          rsp_d.g     = alu_flags[1];
          rsp_d.l     = alu_flags[0];
          cnt_d       = '0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and data registers; reset drops any in-flight transaction.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      alu_req_q <= '0;
      rsp_q     <= '0;
      id_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_req_q <= alu_req_d;
      rsp_q     <= rsp_d;
      id_q      <= id_d;
    end
  end

  // Outputs decoded from the current state and registered data.
  always_comb begin
    alu_ce    = (state_q == ISSUE) || (state_q == WAIT);
    rsp_valid = (state_q == RESP);
    rsp_pkt   = rsp_q;
    alu_req   = alu_req_q;
  end

endmodule
